// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multicycle ALU.
//   - 4-bit operation codes for ALUControl
//   - FSM state encoding for the iterative sequencer
//   - helpers classifying operations as iterative / divide
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_SLTU  = 4'b1011;
  localparam logic [3:0] OP_MULHU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;
  localparam logic [3:0] OP_RSVD  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  // Operations that go through the shift-add / restoring-divide datapath.
  function automatic logic is_iterative(input logic [3:0] op);
    case (op)
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: is_iterative = 1'b1;
      default:                            is_iterative = 1'b0;
    endcase
  endfunction

  // Operations that run the datapath in divide mode.
  function automatic logic is_divide(input logic [3:0] op);
    case (op)
      OP_DIVU, OP_REMU: is_divide = 1'b1;
      default:          is_divide = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: iterative unsigned multiply / restoring divide.
// One iteration per step; WIDTH steps produce the full result.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load          capture operands, clear accumulator and counter
//   step          perform one iteration
//   mode_div      sampled on load: 1 = divide, 0 = multiply
//   a, b          operands (a = multiplier / dividend, b = multiplicand / divisor)
//   lo, hi        multiply: product low/high; divide: quotient/remainder
//   last          counter is at the final iteration (WIDTH-1)
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    count;
  logic             div_mode;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  assign lo   = acc_lo;
  assign hi   = acc_hi;
  assign last = (count == CW'(WIDTH - 1));

  // Next accumulator value for one multiply or divide iteration.
  always_comb begin
    // Multiply: {hi,lo} holds partial product and remaining multiplier bits;
    // add multiplicand into hi when the multiplier LSB is set, then shift right.
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH + 1){1'b0}});
    // Divide: shift next dividend bit into the partial remainder and trial-subtract.
    // The remainder stays below the divisor, so bit WIDTH of the difference is a
    // clean borrow flag. With a zero divisor every trial succeeds, giving an
    // all-ones quotient and the dividend as remainder.
    rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd};
    if (div_mode) begin
      if (!rem_diff[WIDTH]) begin
        nxt_hi = rem_diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_shift[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = add_sum[WIDTH:1];
      nxt_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Accumulator, operand and iteration counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hi   <= {WIDTH{1'b0}};
      acc_lo   <= {WIDTH{1'b0}};
      opnd     <= {WIDTH{1'b0}};
      count    <= {CW{1'b0}};
      div_mode <= 1'b0;
    end else if (load) begin
      acc_hi   <= {WIDTH{1'b0}};
      acc_lo   <= a;
      opnd     <= b;
      count    <= {CW{1'b0}};
      div_mode <= mode_div;
    end else if (step) begin
      acc_hi   <= nxt_hi;
      acc_lo   <= nxt_lo;
      count    <= count + {{(CW - 1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU with single-cycle ops and iterative
// mul/mulhu/divu/remu behind a Start/Busy/Done handshake.
// Ports:
//   Clk, Reset        clock, asynchronous active-high reset
//   Start             request; ALUControl, A, B sampled on the same edge
//   ALUControl        4-bit operation select (codes in alu_pkg)
//   A, B              operands; B[SHW-1:0] is the shift amount
//   ALUResult, Zero   registered result and its zero flag
//   DivByZero         last completed op was divu/remu with B == 0
//   Busy              iterative op in progress (RUN or FIN)
//   Done              one-cycle pulse when outputs are updated
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             DivByZero,
  output logic             Busy,
  output logic             Done
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic [3:0]       op_q;
  logic             b_zero;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH-1:0] it_lo;
  logic [WIDTH-1:0] it_hi;
  logic             it_last;
  logic             it_load;
  logic             it_step;

  assign shamt   = B[SHW-1:0];
  // Start is only accepted in IDLE; RUN and FIN ignore it.
  assign it_load = (state == IDLE) && Start && is_iterative(ALUControl);
  assign it_step = (state == RUN);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk      (Clk),
    .rst      (Reset),
    .load     (it_load),
    .step     (it_step),
    .mode_div (is_divide(ALUControl)),
    .a        (A),
    .b        (B),
    .lo       (it_lo),
    .hi       (it_hi),
    .last     (it_last)
  );

  // Single-cycle ALU result.
  always_comb begin
    alu_out = {WIDTH{1'b0}};
    case (ALUControl)
      OP_ADD:  alu_out = A + B;
      OP_SUB:  alu_out = A - B;
      OP_AND:  alu_out = A & B;
      OP_OR:   alu_out = A | B;
      OP_NOR:  alu_out = ~(A | B);
      OP_XOR:  alu_out = A ^ B;
      OP_SRL:  alu_out = A >> shamt;
      OP_SLL:  alu_out = A << shamt;
      OP_SRA:  alu_out = $unsigned($signed(A) >>> shamt);
      OP_SLT:  alu_out = {{(WIDTH - 1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_out = {{(WIDTH - 1){1'b0}}, (A < B)};
      default: alu_out = {WIDTH{1'b0}};
    endcase
  end

  // Selects the word of the iterative datapath the latched op returns.
  always_comb begin
    iter_res = it_lo;
    case (op_q)
      OP_MUL:   iter_res = it_lo;
      OP_MULHU: iter_res = it_hi;
      OP_DIVU:  iter_res = it_lo;
      OP_REMU:  iter_res = it_hi;
      default:  iter_res = it_lo;
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      op_q      <= 4'b0000;
      b_zero    <= 1'b0;
      ALUResult <= {WIDTH{1'b0}};
      Zero      <= 1'b1;
      DivByZero <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (is_iterative(ALUControl)) begin
              op_q   <= ALUControl;
              b_zero <= (B == {WIDTH{1'b0}});
              Busy   <= 1'b1;
              state  <= RUN;
            end else begin
              ALUResult <= alu_out;
              Zero      <= (alu_out == {WIDTH{1'b0}});
              DivByZero <= 1'b0;
              Done      <= 1'b1;
            end
          end
        end
        RUN: begin
          // The final iteration happens on this edge; FIN then commits.
          if (it_last) begin
            state <= FIN;
          end
        end
        FIN: begin
          ALUResult <= iter_res;
          Zero      <= (iter_res == {WIDTH{1'b0}});
          DivByZero <= is_divide(op_q) && b_zero;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed self-checking bench for alu_multicycle (WIDTH = 32).
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [3:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        DivByZero;
  logic        Busy;
  logic        Done;

  int total = 0;
  int bad   = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ALUControl (ALUControl),
    .A          (A),
    .B          (B),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .DivByZero  (DivByZero),
    .Busy       (Busy),
    .Done       (Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive a request for one cycle; returns just after the sampling edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUControl = op;
    A          = a;
    B          = b;
    Start      = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b);
    chk({tag, "_done"}, {31'd0, Done}, 32'd1);
    chk(tag, ALUResult, exp);
    chk({tag, "_zero"}, {31'd0, Zero}, {31'd0, (exp == 32'd0)});
  endtask

  // Iterative op: counts edges until Done and cycles with Busy high.
  // With inject set, a competing Start is raised for one cycle mid-run.
  task automatic run_iter(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output int edges, output int busy_cyc);
    issue(op, a, b);
    edges    = 0;
    busy_cyc = Busy ? 1 : 0;
    while (!Done && edges < 40) begin
      if (inject && edges == 5) begin
        ALUControl = OP_ADD;
        A          = 32'd1;
        B          = 32'd1;
        Start      = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk);
      #1;
      edges++;
      if (Busy) busy_cyc++;
    end
    Start = 1'b0;
  endtask

  initial begin
    int edges;
    int busy_cyc;
    int done_seen;

    Reset      = 1'b1;
    Start      = 1'b0;
    ALUControl = 4'b0000;
    A          = 32'd0;
    B          = 32'd0;
    @(posedge Clk);
    #1;
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_zero", {31'd0, Zero}, 32'd1);
    chk("rst_dbz", {31'd0, DivByZero}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Single-cycle ops
    single("add", OP_ADD, 32'd10, 32'd20, 32'd30);
    @(posedge Clk);
    #1;
    chk("done_pulse_len", {31'd0, Done}, 32'd0);
    chk("hold_result", ALUResult, 32'd30);
    single("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
    single("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    single("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    single("or", OP_OR, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
    single("nor", OP_NOR, 32'hF000_0001, 32'h0000_0F00, 32'h0FFF_F0FE);
    single("xor", OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0);
    single("sra", OP_SRA, 32'h8000_0010, 32'd4, 32'hF800_0001);
    single("srl", OP_SRL, 32'h8000_0010, 32'd4, 32'h0800_0001);
    single("sll", OP_SLL, 32'd5, 32'd34, 32'd20);
    single("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    single("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    single("rsvd", OP_RSVD, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);

    // Multiply with a competing Start mid-run (must be ignored)
    run_iter(OP_MUL, 32'h0001_0000, 32'h0003_0000, 1'b1, edges, busy_cyc);
    chk("mul_latency", edges, 32'd33);
    chk("mul_busy_cycles", busy_cyc, 32'd33);
    chk("mul", ALUResult, 32'd0);
    chk("mul_zero", {31'd0, Zero}, 32'd1);
    chk("mul_busy_fall", {31'd0, Busy}, 32'd0);
    run_iter(OP_MULHU, 32'h0001_0000, 32'h0003_0000, 1'b0, edges, busy_cyc);
    chk("mulhu_latency", edges, 32'd33);
    chk("mulhu", ALUResult, 32'd3);
    chk("mulhu_zero", {31'd0, Zero}, 32'd0);
    run_iter(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, edges, busy_cyc);
    chk("mul_big", ALUResult, 32'd1);

    // Divide
    run_iter(OP_DIVU, 32'd100, 32'd7, 1'b0, edges, busy_cyc);
    chk("divu_latency", edges, 32'd33);
    chk("divu", ALUResult, 32'd14);
    chk("divu_dbz", {31'd0, DivByZero}, 32'd0);
    run_iter(OP_REMU, 32'd100, 32'd7, 1'b0, edges, busy_cyc);
    chk("remu", ALUResult, 32'd2);
    chk("remu_dbz", {31'd0, DivByZero}, 32'd0);
    run_iter(OP_DIVU, 32'd100, 32'd0, 1'b0, edges, busy_cyc);
    chk("divu0_latency", edges, 32'd33);
    chk("divu0", ALUResult, 32'hFFFF_FFFF);
    chk("divu0_dbz", {31'd0, DivByZero}, 32'd1);
    run_iter(OP_REMU, 32'd100, 32'd0, 1'b0, edges, busy_cyc);
    chk("remu0", ALUResult, 32'd100);
    chk("remu0_dbz", {31'd0, DivByZero}, 32'd1);
    single("add_clr_dbz", OP_ADD, 32'd1, 32'd2, 32'd3);
    chk("dbz_cleared", {31'd0, DivByZero}, 32'd0);
    run_iter(OP_REMU, 32'hDEAD_BEEF, 32'h0001_0000, 1'b0, edges, busy_cyc);
    chk("remu_big", ALUResult, 32'h0000_BEEF);

    // Reset mid-RUN aborts without Done
    issue(OP_MUL, 32'd3, 32'd5);
    repeat (10) begin
      @(posedge Clk);
      #1;
    end
    Reset = 1'b1;
    #2;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_done", {31'd0, Done}, 32'd0);
    chk("abort_result", ALUResult, 32'd0);
    chk("abort_zero", {31'd0, Zero}, 32'd1);
    Reset     = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Done) done_seen++;
    end
    chk("abort_no_done", done_seen, 32'd0);
    chk("abort_hold", ALUResult, 32'd0);

    // Back-to-back: add issued in the Done cycle of a mul
    run_iter(OP_MUL, 32'd6, 32'd7, 1'b0, edges, busy_cyc);
    chk("b2b_mul", ALUResult, 32'd42);
    chk("b2b_mul_done", {31'd0, Done}, 32'd1);
    single("b2b_add", OP_ADD, 32'd10, 32'd20, 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
